regwr_sched: RTL and testbench

Write-port scheduler for the 16×8 register file. It shares the file's single write port between three writeback requesters (ALU, load unit, move-immediate) using round-robin arbitration, and registers the winning write onto `write_en`/`wr_addr`/`val_in`. It provides a read-bypass for the write currently in flight. It also runs a soft-clear sequence that zeroes all 16 registers without a global reset. It sits between the execute/writeback stages and the register file.

---
 rtl/regwr_sched_pkg.sv | 21 ++
 rtl/regwr_sched_if.sv | 25 ++
 rtl/regwr_sched_rr_arbiter.sv | 30 +++
 rtl/regwr_sched.sv | 117 +++++++++++
 tb/tb_regwr_sched.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/regwr_sched_pkg.sv
// Shared constants and types for the register-file write-port scheduler.
// Requester indices, widths, FSM state type and soft-clear bound.
package regwr_pkg;

  localparam int NREQ  = 3;
  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int PTR_W = $clog2(NREQ);

  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;
  localparam int REQ_MOV  = 2;

  localparam logic [AW-1:0] CLEAR_LAST = AW'(15);

  typedef enum logic {
    IDLE,
    CLEAR
  } regwr_state_t;

endpackage

// File: rtl/regwr_sched_if.sv
// Writeback requester bundle: per-requester valid/addr/data and one-hot ready.
// master = requesters, slave = scheduler.
interface regwr_sched_if;
  import regwr_pkg::*;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/regwr_sched_rr_arbiter.sv
// Rotating-priority grant: search valid from ptr upward mod NREQ.
// Ports: valid, ptr in; one-hot gnt, encoded idx, any out.
module rr_arbiter
  import regwr_pkg::*;
(
  input  logic [NREQ-1:0]  valid,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  logic [PTR_W-1:0] k;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    k   = '0;
    for (int i = 0; i < NREQ; i++) begin
      k = PTR_W'((int'(ptr) + i) % NREQ);
      if (!any && valid[k]) begin
        any    = 1'b1;
        gnt[k] = 1'b1;
        idx    = k;
      end
    end
  end

endmodule

// File: rtl/regwr_sched.sv
// Round-robin write-port scheduler with in-flight bypass and soft-clear.
// Ports: clk, reset, req bundle, wr_hold, clear, write port, bypass snoop.
module regwr_sched
  import regwr_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  regwr_sched_if.slave  req,
  input  logic          wr_hold,
  input  logic          clear,
  output logic          clear_busy,
  output logic          write_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] val_in,
  input  logic [AW-1:0] rd_addr1,
  input  logic [AW-1:0] rd_addr2,
  output logic          byp_hit1,
  output logic          byp_hit2,
  output logic [DW-1:0] byp_data
);

  regwr_state_t     state, state_n;
  logic [PTR_W-1:0] ptr, ptr_n;
  logic [AW-1:0]    cnt, cnt_n;
  logic             we_n;
  logic [AW-1:0]    addr_n;
  logic [DW-1:0]    data_n;

  logic [NREQ-1:0]  gnt;
  logic [PTR_W-1:0] gidx;
  logic             gany;

  logic [AW-1:0] addr_a [NREQ];
  logic [DW-1:0] data_a [NREQ];

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      addr_a[i] = req.req_addr[i*AW +: AW];
      data_a[i] = req.req_data[i*DW +: DW];
    end
  end

  rr_arbiter u_arb (
    .valid (req.req_valid),
    .ptr   (ptr),
    .gnt   (gnt),
    .idx   (gidx),
    .any   (gany)
  );

  // The clear-start edge already loads the first zero write,
  // so wr_addr tracks cnt on every CLEAR cycle.
  always_comb begin
    state_n       = state;
    ptr_n         = ptr;
    cnt_n         = cnt;
    we_n          = 1'b0;
    addr_n        = wr_addr;
    data_n        = val_in;
    req.req_ready = '0;
    unique case (state)
      IDLE: begin
        if (clear) begin
          state_n = CLEAR;
          cnt_n   = '0;
          we_n    = 1'b1;
          addr_n  = '0;
          data_n  = '0;
        end else if (!wr_hold) begin
          req.req_ready = gnt;
          if (gany) begin
            we_n   = 1'b1;
            addr_n = addr_a[gidx];
            data_n = data_a[gidx];
            ptr_n  = (gidx == PTR_W'(NREQ-1)) ?
                     '0 : gidx + PTR_W'(1);
          end
        end
      end
      CLEAR: begin
        cnt_n = cnt + AW'(1);
        if (cnt == CLEAR_LAST) begin
          state_n = IDLE;
        end else begin
          we_n   = 1'b1;
          addr_n = cnt + AW'(1);
          data_n = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      ptr      <= '0;
      cnt      <= '0;
      write_en <= 1'b0;
      wr_addr  <= '0;
      val_in   <= '0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      cnt      <= cnt_n;
      write_en <= we_n;
      wr_addr  <= addr_n;
      val_in   <= data_n;
    end
  end

  assign clear_busy = (state == CLEAR);
  assign byp_hit1   = write_en && (wr_addr == rd_addr1);
  assign byp_hit2   = write_en && (wr_addr == rd_addr2);
  assign byp_data   = val_in;

endmodule

// File: tb/tb_regwr_sched.sv
// Directed bench for regwr_sched with a 16x8 register-file model.
// Inputs change 1ns after posedge; outputs sampled on negedge.
module tb_regwr_sched;
  import regwr_pkg::*;

  logic          clk;
  logic          reset;
  logic          wr_hold;
  logic          clear;
  logic          clear_busy;
  logic          write_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] val_in;
  logic [AW-1:0] rd_addr1;
  logic [AW-1:0] rd_addr2;
  logic          byp_hit1;
  logic          byp_hit2;
  logic [DW-1:0] byp_data;

  regwr_sched_if rq ();

  regwr_sched dut (
    .clk        (clk),
    .reset      (reset),
    .req        (rq.slave),
    .wr_hold    (wr_hold),
    .clear      (clear),
    .clear_busy (clear_busy),
    .write_en   (write_en),
    .wr_addr    (wr_addr),
    .val_in     (val_in),
    .rd_addr1   (rd_addr1),
    .rd_addr2   (rd_addr2),
    .byp_hit1   (byp_hit1),
    .byp_hit2   (byp_hit2),
    .byp_data   (byp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] rf [16];

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 8'hFF;
  end

  always @(posedge clk) begin
    if (write_en) rf[wr_addr] <= val_in;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_req(input logic [2:0] v,
                         input logic [3:0] a0, input logic [7:0] d0,
                         input logic [3:0] a1, input logic [7:0] d1,
                         input logic [3:0] a2, input logic [7:0] d2);
    rq.req_valid = v;
    rq.req_addr  = {a2, a1, a0};
    rq.req_data  = {d2, d1, d0};
  endtask

  logic [2:0] exp_gnt [6];
  logic [7:0] acc;

  initial begin
    reset    = 1'b0;
    wr_hold  = 1'b0;
    clear    = 1'b0;
    rd_addr1 = '0;
    rd_addr2 = '0;
    set_req(3'b110, 4'd0, 8'h0, 4'd0, 8'h0, 4'd0, 8'h0);
    #2;
    check("rst_we", 32'(write_en), 32'd0);
    check("rst_addr", 32'(wr_addr), 32'd0);
    check("rst_val", 32'(val_in), 32'd0);
    check("rst_busy", 32'(clear_busy), 32'd0);
    check("rst_ready", 32'(rq.req_ready), 32'b010);
    rq.req_valid = 3'b000;
    mid();
    reset = 1'b1;

    // single ALU write
    tick();
    set_req(3'b001, 4'd3, 8'h5A, 4'd0, 8'h0, 4'd0, 8'h0);
    mid();
    check("t1_ready", 32'(rq.req_ready), 32'b001);
    tick();
    rq.req_valid = 3'b000;
    check("t1_we", 32'(write_en), 32'd1);
    check("t1_addr", 32'(wr_addr), 32'd3);
    check("t1_val", 32'(val_in), 32'h5A);
    tick();
    check("t1_rf3", 32'(rf[3]), 32'h5A);
    check("t1_we_off", 32'(write_en), 32'd0);

    // MOV alone moves ptr back to 0
    set_req(3'b100, 4'd0, 8'h0, 4'd0, 8'h0, 4'd1, 8'h01);
    mid();
    check("mov_ready", 32'(rq.req_ready), 32'b100);
    tick();
    rq.req_valid = 3'b000;

    // all three valid for 6 cycles
    exp_gnt[0] = 3'b001; exp_gnt[1] = 3'b010; exp_gnt[2] = 3'b100;
    exp_gnt[3] = 3'b001; exp_gnt[4] = 3'b010; exp_gnt[5] = 3'b100;
    set_req(3'b111, 4'd4, 8'h40, 4'd5, 8'h50, 4'd6, 8'h60);
    for (int i = 0; i < 6; i++) begin
      mid();
      check($sformatf("rr_gnt%0d", i),
            32'(rq.req_ready), 32'(exp_gnt[i]));
      if (i > 0) begin
        check($sformatf("rr_we%0d", i), 32'(write_en), 32'd1);
        check($sformatf("rr_addr%0d", i), 32'(wr_addr),
              32'(4 + ((i - 1) % 3)));
      end
      tick();
    end
    rq.req_valid = 3'b000;
    check("rr_we_last", 32'(write_en), 32'd1);
    check("rr_addr_last", 32'(wr_addr), 32'd6);
    tick();
    check("rr_we_off", 32'(write_en), 32'd0);

    // same destination from ALU and LOAD
    set_req(3'b011, 4'd7, 8'h11, 4'd7, 8'h22, 4'd0, 8'h0);
    mid();
    check("same_gnt0", 32'(rq.req_ready), 32'b001);
    tick();
    rq.req_valid = 3'b010;
    check("same_val0", 32'(val_in), 32'h11);
    check("same_addr0", 32'(wr_addr), 32'd7);
    mid();
    check("same_gnt1", 32'(rq.req_ready), 32'b010);
    tick();
    rq.req_valid = 3'b000;
    check("same_val1", 32'(val_in), 32'h22);
    tick();
    check("same_rf7", 32'(rf[7]), 32'h22);

    // hold for three cycles with LOAD valid
    wr_hold = 1'b1;
    set_req(3'b010, 4'd0, 8'h0, 4'd2, 8'h33, 4'd0, 8'h0);
    for (int i = 0; i < 3; i++) begin
      mid();
      check($sformatf("hold_ready%0d", i), 32'(rq.req_ready), 32'd0);
      check($sformatf("hold_we%0d", i), 32'(write_en), 32'd0);
      tick();
    end
    wr_hold = 1'b0;
    mid();
    check("hold_release", 32'(rq.req_ready), 32'b010);
    tick();
    rq.req_valid = 3'b000;
    check("hold_we", 32'(write_en), 32'd1);
    check("hold_val", 32'(val_in), 32'h33);

    // clear beats a same-cycle ALU request
    clear = 1'b1;
    set_req(3'b001, 4'hE, 8'h44, 4'd0, 8'h0, 4'd0, 8'h0);
    mid();
    check("clr_nogrant", 32'(rq.req_ready), 32'd0);
    tick();
    clear = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k == 3) clear = 1'b1;
      mid();
      check($sformatf("clr_busy%0d", k), 32'(clear_busy), 32'd1);
      check($sformatf("clr_we%0d", k), 32'(write_en), 32'd1);
      check($sformatf("clr_addr%0d", k), 32'(wr_addr), 32'(k));
      check($sformatf("clr_val%0d", k), 32'(val_in), 32'd0);
      check($sformatf("clr_rdy%0d", k), 32'(rq.req_ready), 32'd0);
      tick();
      clear = 1'b0;
    end
    mid();
    check("clr_done", 32'(clear_busy), 32'd0);
    check("clr_alu_gnt", 32'(rq.req_ready), 32'b001);
    acc = '0;
    for (int i = 0; i < 16; i++) acc = acc | rf[i];
    check("clr_rf_zero", 32'(acc), 32'd0);
    tick();
    rq.req_valid = 3'b000;
    check("clr_alu_addr", 32'(wr_addr), 32'hE);
    check("clr_alu_val", 32'(val_in), 32'h44);

    // bypass of an in-flight write
    set_req(3'b001, 4'd9, 8'hC3, 4'd0, 8'h0, 4'd0, 8'h0);
    rd_addr1 = 4'd9;
    rd_addr2 = 4'd4;
    mid();
    check("byp_gnt", 32'(rq.req_ready), 32'b001);
    tick();
    rq.req_valid = 3'b000;
    mid();
    check("byp_hit1", 32'(byp_hit1), 32'd1);
    check("byp_hit2", 32'(byp_hit2), 32'd0);
    check("byp_data", 32'(byp_data), 32'hC3);
    tick();
    check("byp_hit1_off", 32'(byp_hit1), 32'd0);

    // reset during CLEAR at cnt=5
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    mid();
    check("mid_addr5", 32'(wr_addr), 32'd5);
    check("mid_busy", 32'(clear_busy), 32'd1);
    reset = 1'b0;
    #1;
    check("ar_we", 32'(write_en), 32'd0);
    check("ar_addr", 32'(wr_addr), 32'd0);
    check("ar_val", 32'(val_in), 32'd0);
    check("ar_busy", 32'(clear_busy), 32'd0);
    check("ar_state", 32'(dut.state), 32'(IDLE));
    rq.req_valid = 3'b011;
    #1;
    check("ar_ptr0", 32'(rq.req_ready), 32'b001);
    rq.req_valid = 3'b000;
    mid();
    reset = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
